smc_cfg_reader8: RTL

Initiator-side sequencer that sweeps the SMC's per-chip-select config register bank after a start request. For each chip select it drives a one-hot select, waits a programmable read latency, captures the 32-bit read data, and checks the two presence flags (bits 31:30). Captured words and per-CS valid flags are held in shadow registers for the SMC timing logic and for software readback. It sits between the SMC control FSM and the config register instances, which share one OR'd read-data bus.

---
 rtl/smc_cfg_reader8.sv | 138 +++++++++++++
 1 files changed

// File: rtl/smc_cfg_reader8.sv
// smc_cfg_reader8: sweeps the per-chip-select config register bank after a
// start request, capturing each word into a shadow register and flagging
// chip selects whose presence bits (31:30) are not both set.
module smc_cfg_reader8 #(
  parameter int unsigned NUM_CS   = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              hclk8,
  input  logic              sys_reset8,
  input  logic              start8,
  input  logic [31:0]       rdata8,
  output logic [NUM_CS-1:0] selreg8,
  output logic              busy8,
  output logic              done8,
  output logic              err8,
  output logic [NUM_CS-1:0] cs_valid8,
  input  logic [2:0]        cfg_sel8,
  output logic [31:0]       cfg_out8
);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    GAP,
    FIN
  } state_t;

  localparam logic [2:0] LAT  = 3'(READ_LAT);
  localparam logic [2:0] LAST = 3'(NUM_CS - 1);

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NUM_CS-1:0] sel_d;
  logic              capture;
  logic              clear;
  logic              present;
  logic [31:0]       shadow [NUM_CS];

  assign present = (rdata8[31:30] == 2'b11);
  assign busy8   = (state_q != IDLE);
  assign done8   = (state_q == FIN);

  // Next-state, next select and capture/clear strobes for the sweep.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = selreg8;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start8) begin
          state_d = SEL;
          idx_d   = '0;
          cnt_d   = '0;
          sel_d   = NUM_CS'(1);
          clear   = 1'b1;
        end
      end
      SEL: begin
        if (cnt_q == LAT) begin
          capture = 1'b1;
          sel_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      GAP: begin
        if (idx_q < LAST) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          sel_d   = NUM_CS'(1) << idx_d;
          state_d = SEL;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, select and shadow/result registers; reset discards partial sweeps.
  always_ff @(posedge hclk8 or posedge sys_reset8) begin
    if (sys_reset8) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      selreg8   <= '0;
      err8      <= 1'b0;
      cs_valid8 <= '0;
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      selreg8 <= sel_d;
      if (clear) begin
        err8      <= 1'b0;
        cs_valid8 <= '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
          shadow[i] <= '0;
        end
      end
      if (capture) begin
        if (!present) begin
          err8 <= 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CS; i++) begin
          if (idx_q == 3'(i)) begin
            shadow[i]    <= rdata8;
            cs_valid8[i] <= present;
          end
        end
      end
    end
  end

  // Readback mux; indices beyond the implemented chip selects read as zero.
  always_comb begin
    cfg_out8 = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cfg_sel8 == 3'(i)) begin
        cfg_out8 = shadow[i];
      end
    end
  end

endmodule
